id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register with a built-in load-use hazard controller.
- Captures the decoded instruction, operands and control bundle from the ID stage, and presents them to EX one cycle later.
- Detects load-use dependencies against the instruction currently in EX. Inserts 1 or 2 bubbles and raises stall_out to freeze the PC and IF/ID register.
- Honours a branch flush from EX/MEM and a downstream hold.

Parameters:
DATA_W, 32, datapath / PC width
REG_W, 5, register-address width
CTRL_W, 10, control bundle width; bit map [3:0] alu_op, [4] alu_src, [5] reg_dst, [6] mem_to_reg, [7] mem_write, [8] mem_read, [9] reg_write
LOAD_USE_BUBBLES, 1, bubbles per load-use hazard; legal values 1 (MEM->EX forwarding present) or 2

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
valid_id  in  1  ID holds a real instruction
pc_id  in  DATA_W  PC of ID instruction
rs_id  in  REG_W  source register 1
rt_id  in  REG_W  source register 2
rd_id  in  REG_W  destination (R-type)
uses_rs_id  in  1  instruction reads rs
uses_rt_id  in  1  instruction reads rt
rdata1_id  in  DATA_W  register file port 1 data
rdata2_id  in  DATA_W  register file port 2 data
imm_id  in  DATA_W  extended immediate
ctrl_id  in  CTRL_W  control bundle
flush  in  1  branch/jump taken: kill ID and the ID/EX contents
hold  in  1  downstream not ready: freeze ID/EX and FSM
stall_out  out  1  freeze PC and IF/ID this cycle
valid_ex  out  1  EX holds a real instruction
pc_ex  out  DATA_W  registered pc_id
rs_ex  out  REG_W  registered rs_id
rt_ex  out  REG_W  registered rt_id
rd_ex  out  REG_W  registered rd_id
rdata1_ex  out  DATA_W  registered rdata1_id
rdata2_ex  out  DATA_W  registered rdata2_id
imm_ex  out  DATA_W  registered imm_id
ctrl_ex  out  CTRL_W  registered ctrl_id

Behaviour:
- Reset (rst=0, asynchronous):
  - All registered outputs are 0, valid_ex=0.
  - FSM goes to RUN with bubble counter cnt=0.
  - stall_out=0 during reset.
- Bubble definition: valid_ex=0 and ctrl_ex=0. pc/operand fields are don't-care but must load 0.
- hazard is combinational: valid_id & valid_ex & ctrl_ex[8] & (rt_ex!=0) & ((uses_rs_id & rs_id==rt_ex) | (uses_rt_id & rt_id==rt_ex)).
- Per-edge priority: flush > hold > FSM action.
- flush=1:
  - Load a bubble and force state RUN, cnt=0.
  - stall_out=0 in that cycle.
  - Applies in any state, including mid-stall.
- hold=1 (with flush=0):
  - Every ID/EX register and the FSM keep their value.
  - stall_out=1.
- FSM state RUN:
  - hazard=0: load ID fields (valid_ex<=valid_id), stall_out=0.
  - hazard=1: stall_out=1 (combinational, same cycle) and load a bubble.
  - If LOAD_USE_BUBBLES==2, go to STALL with cnt<=1; otherwise stay in RUN.
- FSM state STALL:
  - stall_out=1 and load a bubble.
  - cnt decrements; return to RUN when cnt reaches 0.
  - Do not re-evaluate hazard in STALL. The ID instruction is unchanged because IF/ID is frozen.
- Latency: 1 cycle, ID to EX.
- Back-to-back loads with a dependency are handled naturally: each load-use pair costs LOAD_USE_BUBBLES cycles.
- rt_ex=0 never triggers a hazard (register $0).
- A simultaneous hazard and flush produces no stall.

Optional Feature:
ID_EX_PERF_EN
- Defined:
  - Adds outputs bubble_cnt [31:0] and flush_cnt [31:0].
  - bubble_cnt increments on each hazard-inserted bubble edge.
  - flush_cnt increments on each flush edge.
  - Both counters saturate at 0xFFFFFFFF, are reset to 0, and are frozen by hold.
- Undefined: the ports and counters do not exist. Core behaviour is identical.

Test Plan:
- Reset release, valid_id=1, pc_id=0x4, ctrl_id=0x201, rdata1_id=0x11 -> next edge valid_ex=1, pc_ex=0x4, ctrl_ex=0x201, rdata1_ex=0x11; stall_out=0 throughout.
- lw with rt=8 in EX (ctrl_ex[8]=1), ID add with rs=8, uses_rs_id=1, LOAD_USE_BUBBLES=1 -> stall_out=1 for exactly 1 cycle, then one bubble (valid_ex=0, ctrl_ex=0), then the add appears in EX.
- Same as above with LOAD_USE_BUBBLES=2 -> stall_out=1 for 2 consecutive cycles, 2 bubbles, then the add in EX.
- lw with rt=0 in EX, ID uses rs=0 -> no stall; lw with rt=9 in EX, ID rs=9 but uses_rs_id=0 -> no stall.
- flush asserted in the first STALL cycle (LOAD_USE_BUBBLES=2) -> bubble loaded, stall_out=0 that cycle, state RUN; with ID_EX_PERF_EN, flush_cnt=1 and bubble_cnt=1.
- hold=1 for 3 cycles with valid instruction in EX -> all *_ex outputs unchanged, stall_out=1; rst pulled low mid-hold -> all outputs 0 immediately.

Source files
------------

// File: rtl/id_ex_if.sv
// ID/EX stage bundle: decoded ID-side fields in, registered EX-side fields out,
// plus the flush/hold controls and the stall request back to the front end.
interface id_ex_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 10
);
  logic              valid_id;
  logic [DATA_W-1:0] pc_id;
  logic [REG_W-1:0]  rs_id;
  logic [REG_W-1:0]  rt_id;
  logic [REG_W-1:0]  rd_id;
  logic              uses_rs_id;
  logic              uses_rt_id;
  logic [DATA_W-1:0] rdata1_id;
  logic [DATA_W-1:0] rdata2_id;
  logic [DATA_W-1:0] imm_id;
  logic [CTRL_W-1:0] ctrl_id;
  logic              flush;
  logic              hold;
  logic              stall_out;
  logic              valid_ex;
  logic [DATA_W-1:0] pc_ex;
  logic [REG_W-1:0]  rs_ex;
  logic [REG_W-1:0]  rt_ex;
  logic [REG_W-1:0]  rd_ex;
  logic [DATA_W-1:0] rdata1_ex;
  logic [DATA_W-1:0] rdata2_ex;
  logic [DATA_W-1:0] imm_ex;
  logic [CTRL_W-1:0] ctrl_ex;

  modport master (
    output valid_id, pc_id, rs_id, rt_id, rd_id, uses_rs_id, uses_rt_id,
           rdata1_id, rdata2_id, imm_id, ctrl_id, flush, hold,
    input  stall_out, valid_ex, pc_ex, rs_ex, rt_ex, rd_ex,
           rdata1_ex, rdata2_ex, imm_ex, ctrl_ex
  );

  modport slave (
    input  valid_id, pc_id, rs_id, rt_id, rd_id, uses_rs_id, uses_rt_id,
           rdata1_id, rdata2_id, imm_id, ctrl_id, flush, hold,
    output stall_out, valid_ex, pc_ex, rs_ex, rt_ex, rd_ex,
           rdata1_ex, rdata2_ex, imm_ex, ctrl_ex
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard controller (bubble insertion + stall).
// Optional macro ID_EX_PERF_EN adds saturating bubble_cnt / flush_cnt outputs.
//
// state | meaning
// RUN   | normal flow; hazard check against the instruction in EX
// STALL | extra bubbles owed after a load-use hazard (LOAD_USE_BUBBLES=2)
module id_ex_stage #(
  parameter int DATA_W           = 32,
  parameter int REG_W            = 5,
  parameter int CTRL_W           = 10,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  id_ex_if.slave      bus
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0] bubble_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  localparam logic [1:0] CNT_INIT = 2'(LOAD_USE_BUBBLES - 1);

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       hazard;
  logic       load_id;
  logic       load_bubble;
  logic       haz_bubble;
  logic       stall_int;

  // ctrl[8] is mem_read; register $0 never creates a dependency
  assign hazard = bus.valid_id & bus.valid_ex & bus.ctrl_ex[8] &
                  (bus.rt_ex != {REG_W{1'b0}}) &
                  ((bus.uses_rs_id & (bus.rs_id == bus.rt_ex)) |
                   (bus.uses_rt_id & (bus.rt_id == bus.rt_ex)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (bus.flush) begin
      state_nxt = RUN;
      cnt_nxt   = 2'd0;
    end else if (!bus.hold) begin
      case (state)
        RUN: begin
          if (hazard && (LOAD_USE_BUBBLES > 1)) begin
            state_nxt = STALL;
            cnt_nxt   = CNT_INIT;
          end
        end
        STALL: begin
          cnt_nxt = cnt - 2'd1;
          if (cnt == 2'd1) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    stall_int   = 1'b0;
    load_id     = 1'b0;
    load_bubble = 1'b0;
    haz_bubble  = 1'b0;
    if (bus.flush) begin
      load_bubble = 1'b1;
    end else if (bus.hold) begin
      stall_int = 1'b1;
    end else if ((state == STALL) || hazard) begin
      stall_int   = 1'b1;
      load_bubble = 1'b1;
      haz_bubble  = 1'b1;
    end else begin
      load_id = 1'b1;
    end
    bus.stall_out = rst & stall_int;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || load_bubble) begin
      bus.valid_ex  <= 1'b0;
      bus.pc_ex     <= {DATA_W{1'b0}};
      bus.rs_ex     <= {REG_W{1'b0}};
      bus.rt_ex     <= {REG_W{1'b0}};
      bus.rd_ex     <= {REG_W{1'b0}};
      bus.rdata1_ex <= {DATA_W{1'b0}};
      bus.rdata2_ex <= {DATA_W{1'b0}};
      bus.imm_ex    <= {DATA_W{1'b0}};
      bus.ctrl_ex   <= {CTRL_W{1'b0}};
    end else if (load_id) begin
      bus.valid_ex  <= bus.valid_id;
      bus.pc_ex     <= bus.pc_id;
      bus.rs_ex     <= bus.rs_id;
      bus.rt_ex     <= bus.rt_id;
      bus.rd_ex     <= bus.rd_id;
      bus.rdata1_ex <= bus.rdata1_id;
      bus.rdata2_ex <= bus.rdata2_id;
      bus.imm_ex    <= bus.imm_id;
      bus.ctrl_ex   <= bus.ctrl_id;
    end
  end

`ifdef ID_EX_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= 32'd0;
      flush_cnt  <= 32'd0;
    end else begin
      if (haz_bubble && (bubble_cnt != 32'hFFFF_FFFF)) bubble_cnt <= bubble_cnt + 32'd1;
      if (bus.flush && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: two instances (LOAD_USE_BUBBLES 1 and 2) share one ID stimulus,
// checked by a directed vector table, hand sequences and a randomized reference model.
module tb_id_ex_stage;

  typedef struct {
    bit          valid;
    logic [31:0] pc;
    logic [4:0]  rs, rt, rd;
    bit          urs, urt;
    logic [31:0] r1, r2, imm;
    logic [9:0]  ctrl;
    bit          flush, hold;
  } in_t;

  typedef struct {
    bit          valid;
    logic [31:0] pc, r1, r2, imm;
    logic [4:0]  rs, rt, rd;
    logic [9:0]  ctrl;
    int          owed;
    logic [31:0] bub, fl;
  } model_t;

  typedef struct {
    in_t         i;
    bit          st1, v1;
    logic [31:0] pc1;
    logic [9:0]  c1;
    bit          st2, v2;
    logic [31:0] pc2;
    logic [9:0]  c2;
  } vec_t;

  logic   clk, rst;
  in_t    in_cur;
  model_t m1, m2, mzero;
  int     checks = 0, passed = 0;
  vec_t   tv[$];

  id_ex_if if1 ();
  id_ex_if if2 ();

`ifdef ID_EX_PERF_EN
  logic [31:0] bc1, fc1, bc2, fc2;
`endif

  id_ex_stage #(.LOAD_USE_BUBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1)
`ifdef ID_EX_PERF_EN
    , .bubble_cnt(bc1), .flush_cnt(fc1)
`endif
  );
  id_ex_stage #(.LOAD_USE_BUBBLES(2)) dut2 (.clk(clk), .rst(rst), .bus(if2)
`ifdef ID_EX_PERF_EN
    , .bubble_cnt(bc2), .flush_cnt(fc2)
`endif
  );

  assign if1.valid_id = in_cur.valid;  assign if2.valid_id = in_cur.valid;
  assign if1.pc_id = in_cur.pc;        assign if2.pc_id = in_cur.pc;
  assign if1.rs_id = in_cur.rs;        assign if2.rs_id = in_cur.rs;
  assign if1.rt_id = in_cur.rt;        assign if2.rt_id = in_cur.rt;
  assign if1.rd_id = in_cur.rd;        assign if2.rd_id = in_cur.rd;
  assign if1.uses_rs_id = in_cur.urs;  assign if2.uses_rs_id = in_cur.urs;
  assign if1.uses_rt_id = in_cur.urt;  assign if2.uses_rt_id = in_cur.urt;
  assign if1.rdata1_id = in_cur.r1;    assign if2.rdata1_id = in_cur.r1;
  assign if1.rdata2_id = in_cur.r2;    assign if2.rdata2_id = in_cur.r2;
  assign if1.imm_id = in_cur.imm;      assign if2.imm_id = in_cur.imm;
  assign if1.ctrl_id = in_cur.ctrl;    assign if2.ctrl_id = in_cur.ctrl;
  assign if1.flush = in_cur.flush;     assign if2.flush = in_cur.flush;
  assign if1.hold = in_cur.hold;       assign if2.hold = in_cur.hold;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic in_t mk(bit v, logic [31:0] pc, logic [4:0] rs, logic [4:0] rt,
                             bit urs, bit urt, logic [9:0] ctrl, bit fl, bit hd);
    in_t i;
    i.valid = v; i.pc = pc; i.rs = rs; i.rt = rt; i.rd = 5'(rt + 5'd1);
    i.urs = urs; i.urt = urt; i.r1 = 32'h11; i.r2 = pc ^ 32'hA5A5_0000;
    i.imm = pc << 2; i.ctrl = ctrl; i.flush = fl; i.hold = hd;
    return i;
  endfunction

  function automatic vec_t vec(in_t i, bit st1, bit v1, logic [31:0] pc1, logic [9:0] c1,
                               bit st2, bit v2, logic [31:0] pc2, logic [9:0] c2);
    vec_t t;
    t.i = i; t.st1 = st1; t.v1 = v1; t.pc1 = pc1; t.c1 = c1;
    t.st2 = st2; t.v2 = v2; t.pc2 = pc2; t.c2 = c2;
    return t;
  endfunction

  // Reference: a load-use pair owes LOAD_USE_BUBBLES empty EX slots; flush cancels any debt.
  function automatic bit m_hazard(model_t m, in_t i);
    return i.valid && m.valid && m.ctrl[8] && (m.rt != 0) &&
           ((i.urs && i.rs == m.rt) || (i.urt && i.rt == m.rt));
  endfunction

  function automatic bit m_stall(model_t m, in_t i);
    if (i.flush) return 1'b0;
    if (i.hold) return 1'b1;
    return (m.owed > 0) || m_hazard(m, i);
  endfunction

  function automatic model_t m_bubble(model_t m);
    model_t n = mzero;
    n.owed = m.owed; n.bub = m.bub; n.fl = m.fl;
    return n;
  endfunction

  function automatic model_t m_next(model_t m, in_t i, int lub);
    model_t n = m;
    if (i.flush) begin
      n = m_bubble(m);
      n.owed = 0;
      if (n.fl != 32'hFFFF_FFFF) n.fl = n.fl + 1;
    end else if (i.hold) begin
      n = m;
    end else if (m.owed > 0 || m_hazard(m, i)) begin
      n = m_bubble(m);
      n.owed = (m.owed > 0) ? m.owed - 1 : lub - 1;
      if (n.bub != 32'hFFFF_FFFF) n.bub = n.bub + 1;
    end else begin
      n.valid = i.valid; n.pc = i.pc; n.rs = i.rs; n.rt = i.rt; n.rd = i.rd;
      n.r1 = i.r1; n.r2 = i.r2; n.imm = i.imm; n.ctrl = i.ctrl;
    end
    return n;
  endfunction

  task automatic cmp_all(input string t, input model_t m, input logic v, input logic [31:0] pc,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                         input logic [9:0] c);
    chk({t, "_valid_ex"}, 32'(v), 32'(m.valid));
    chk({t, "_pc_ex"}, pc, m.pc);
    chk({t, "_rs_ex"}, 32'(rs), 32'(m.rs));
    chk({t, "_rt_ex"}, 32'(rt), 32'(m.rt));
    chk({t, "_rd_ex"}, 32'(rd), 32'(m.rd));
    chk({t, "_rdata1_ex"}, r1, m.r1);
    chk({t, "_rdata2_ex"}, r2, m.r2);
    chk({t, "_imm_ex"}, imm, m.imm);
    chk({t, "_ctrl_ex"}, 32'(c), 32'(m.ctrl));
  endtask

  task automatic cmp_both(input string t);
    cmp_all({t, "1"}, m1, if1.valid_ex, if1.pc_ex, if1.rs_ex, if1.rt_ex, if1.rd_ex,
            if1.rdata1_ex, if1.rdata2_ex, if1.imm_ex, if1.ctrl_ex);
    cmp_all({t, "2"}, m2, if2.valid_ex, if2.pc_ex, if2.rs_ex, if2.rt_ex, if2.rd_ex,
            if2.rdata1_ex, if2.rdata2_ex, if2.imm_ex, if2.ctrl_ex);
`ifdef ID_EX_PERF_EN
    chk({t, "_bubble_cnt1"}, bc1, m1.bub);
    chk({t, "_flush_cnt1"}, fc1, m1.fl);
    chk({t, "_bubble_cnt2"}, bc2, m2.bub);
    chk({t, "_flush_cnt2"}, fc2, m2.fl);
`endif
  endtask

  task automatic step(input in_t i, input string t);
    in_cur = i;
    #1;
    chk({t, "_stall1"}, 32'(if1.stall_out), 32'(m_stall(m1, i)));
    chk({t, "_stall2"}, 32'(if2.stall_out), 32'(m_stall(m2, i)));
    @(posedge clk);
    m1 = m_next(m1, i, 1);
    m2 = m_next(m2, i, 2);
    #1;
    cmp_both(t);
  endtask

  task automatic do_reset();
    in_cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    m1 = mzero; m2 = mzero;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall1", 32'(if1.stall_out), 32'd0);
    chk("reset_stall2", 32'(if2.stall_out), 32'd0);
    cmp_both("reset");
    rst = 1'b1;
  endtask

  function automatic in_t rnd_in();
    in_t i;
    i = mk($urandom_range(0, 9) != 0, $urandom, 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 10'($urandom),
           $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0);
    i.ctrl[8] = $urandom_range(0, 1);
    i.r1 = $urandom; i.rd = 5'($urandom);
    return i;
  endfunction

  initial begin
    mzero = '{valid: 0, pc: 0, r1: 0, r2: 0, imm: 0, rs: 0, rt: 0, rd: 0, ctrl: 0,
              owed: 0, bub: 0, fl: 0};
    //             v  pc     rs rt urs urt ctrl    fl hd     st1 v1 pc1 c1   st2 v2 pc2 c2
    tv.push_back(vec(mk(1, 32'h04, 1, 2, 1, 1, 10'h201, 0, 0), 0, 1, 32'h04, 10'h201, 0, 1, 32'h04, 10'h201));
    tv.push_back(vec(mk(1, 32'h08, 3, 8, 1, 0, 10'h300, 0, 0), 0, 1, 32'h08, 10'h300, 0, 1, 32'h08, 10'h300));
    tv.push_back(vec(mk(1, 32'h0C, 8, 4, 1, 1, 10'h200, 0, 0), 1, 0, 32'h00, 10'h000, 1, 0, 32'h00, 10'h000));
    tv.push_back(vec(mk(1, 32'h0C, 8, 4, 1, 1, 10'h200, 0, 0), 0, 1, 32'h0C, 10'h200, 1, 0, 32'h00, 10'h000));
    tv.push_back(vec(mk(1, 32'h0C, 8, 4, 1, 1, 10'h200, 0, 0), 0, 1, 32'h0C, 10'h200, 0, 1, 32'h0C, 10'h200));
    tv.push_back(vec(mk(1, 32'h14, 1, 0, 1, 0, 10'h300, 0, 0), 0, 1, 32'h14, 10'h300, 0, 1, 32'h14, 10'h300));
    tv.push_back(vec(mk(1, 32'h18, 0, 3, 1, 0, 10'h200, 0, 0), 0, 1, 32'h18, 10'h200, 0, 1, 32'h18, 10'h200));
    tv.push_back(vec(mk(1, 32'h1C, 2, 9, 1, 0, 10'h300, 0, 0), 0, 1, 32'h1C, 10'h300, 0, 1, 32'h1C, 10'h300));
    tv.push_back(vec(mk(1, 32'h20, 9, 1, 0, 1, 10'h200, 0, 0), 0, 1, 32'h20, 10'h200, 0, 1, 32'h20, 10'h200));
    tv.push_back(vec(mk(1, 32'h24, 1, 7, 1, 0, 10'h300, 0, 0), 0, 1, 32'h24, 10'h300, 0, 1, 32'h24, 10'h300));
    tv.push_back(vec(mk(1, 32'h28, 1, 7, 1, 1, 10'h200, 0, 0), 1, 0, 32'h00, 10'h000, 1, 0, 32'h00, 10'h000));
    tv.push_back(vec(mk(1, 32'h28, 1, 7, 1, 1, 10'h200, 0, 0), 0, 1, 32'h28, 10'h200, 1, 0, 32'h00, 10'h000));
    tv.push_back(vec(mk(1, 32'h28, 1, 7, 1, 1, 10'h200, 0, 0), 0, 1, 32'h28, 10'h200, 0, 1, 32'h28, 10'h200));
    tv.push_back(vec(mk(1, 32'h2C, 1, 8, 1, 0, 10'h300, 0, 0), 0, 1, 32'h2C, 10'h300, 0, 1, 32'h2C, 10'h300));
    tv.push_back(vec(mk(1, 32'h30, 8, 2, 1, 0, 10'h200, 0, 0), 1, 0, 32'h00, 10'h000, 1, 0, 32'h00, 10'h000));
    tv.push_back(vec(mk(1, 32'h30, 8, 2, 1, 0, 10'h200, 1, 0), 0, 0, 32'h00, 10'h000, 0, 0, 32'h00, 10'h000));
    tv.push_back(vec(mk(1, 32'h34, 1, 2, 1, 1, 10'h200, 0, 0), 0, 1, 32'h34, 10'h200, 0, 1, 32'h34, 10'h200));
    for (int k = 0; k < 3; k++)
      tv.push_back(vec(mk(1, 32'h38, 1, 2, 1, 1, 10'h200, 0, 1), 1, 1, 32'h34, 10'h200, 1, 1, 32'h34, 10'h200));
    tv.push_back(vec(mk(1, 32'h3C, 1, 5, 1, 0, 10'h300, 0, 0), 0, 1, 32'h3C, 10'h300, 0, 1, 32'h3C, 10'h300));
    tv.push_back(vec(mk(1, 32'h40, 5, 2, 1, 0, 10'h200, 1, 0), 0, 0, 32'h00, 10'h000, 0, 0, 32'h00, 10'h000));
    tv.push_back(vec(mk(1, 32'h44, 5, 2, 1, 0, 10'h200, 0, 0), 0, 1, 32'h44, 10'h200, 0, 1, 32'h44, 10'h200));
    tv.push_back(vec(mk(1, 32'h48, 1, 6, 1, 0, 10'h300, 0, 0), 0, 1, 32'h48, 10'h300, 0, 1, 32'h48, 10'h300));
    tv.push_back(vec(mk(0, 32'h4C, 6, 2, 1, 0, 10'h200, 0, 0), 0, 0, 32'h4C, 10'h200, 0, 0, 32'h4C, 10'h200));
    tv.push_back(vec(mk(1, 32'h50, 1, 2, 1, 1, 10'h2A5, 0, 0), 0, 1, 32'h50, 10'h2A5, 0, 1, 32'h50, 10'h2A5));

    do_reset();

    foreach (tv[r]) begin
      in_cur = tv[r].i;
      #1;
      chk($sformatf("vec%0d_stall1", r), 32'(if1.stall_out), 32'(tv[r].st1));
      chk($sformatf("vec%0d_stall2", r), 32'(if2.stall_out), 32'(tv[r].st2));
      @(posedge clk);
      m1 = m_next(m1, tv[r].i, 1);
      m2 = m_next(m2, tv[r].i, 2);
      #1;
      chk($sformatf("vec%0d_valid1", r), 32'(if1.valid_ex), 32'(tv[r].v1));
      chk($sformatf("vec%0d_pc1", r), if1.pc_ex, tv[r].pc1);
      chk($sformatf("vec%0d_ctrl1", r), 32'(if1.ctrl_ex), 32'(tv[r].c1));
      chk($sformatf("vec%0d_valid2", r), 32'(if2.valid_ex), 32'(tv[r].v2));
      chk($sformatf("vec%0d_pc2", r), if2.pc_ex, tv[r].pc2);
      chk($sformatf("vec%0d_ctrl2", r), 32'(if2.ctrl_ex), 32'(tv[r].c2));
      if (r == 0) chk("vec0_rdata1", if1.rdata1_ex, 32'h11);
    end

    // hold with a live instruction in EX, then async reset in the middle of the hold
    for (int k = 0; k < 3; k++) begin
      step(mk(1, 32'h60, 3, 3, 1, 1, 10'h3FF, 0, 1), "hold");
      chk("hold_pc_kept", if1.pc_ex, 32'h50);
    end
    in_cur = mk(1, 32'h60, 3, 3, 1, 1, 10'h3FF, 0, 1);
    #2;
    rst = 1'b0;
    #1;
    m1 = mzero; m2 = mzero;
    chk("rst_mid_hold_stall1", 32'(if1.stall_out), 32'd0);
    chk("rst_mid_hold_stall2", 32'(if2.stall_out), 32'd0);
    cmp_both("rst_mid_hold");

    do_reset();
    for (int n = 0; n < 600; n++) step(rnd_in(), "rand");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
